rst_req_ctrl: RTL and testbench

RST_REQ_CTRL -- requirements
Module: rst_req_ctrl

---
 rtl/rst_req_ctrl.sv | 135 +++++++++++++
 tb/tb_rst_req_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rst_req_ctrl.sv
// Reset-request controller: turns sw/wdog/debug requests into a handshaked ndmreset pulse.
// Optional sticky cause register enabled by defining RST_REQ_CAUSE_EN.
module rst_req_ctrl #(
  parameter int unsigned MinPulse      = 4,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sw_rst_req_i,
  input  logic       wdog_rst_req_i,
  input  logic       dbg_ndmreset_i,
  input  logic       sys_rst_ni_i,
  input  logic       cause_clr_i,
  output logic       ndmreset_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [3:0] rst_cause_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] MinLast = CntW'(MinPulse - 1);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            low_seen_q, low_seen_d;
  logic            ndm_q, ndm_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic            req_any;

  assign req_any = sw_rst_req_i | wdog_rst_req_i | dbg_ndmreset_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    low_seen_d = low_seen_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d      = '0;
        low_seen_d = 1'b0;
        if (req_any) begin
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        if (!sys_rst_ni_i) begin
          low_seen_d = 1'b1;
        end
        // Once the reset manager has acknowledged, a held debug request only stretches the pulse.
        if (low_seen_q) begin
          if ((cnt_q >= MinLast) && !dbg_ndmreset_i) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end else if (cnt_q == CntLast) begin
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      RELEASE: begin
        if (sys_rst_ni_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    ndm_d  = (state_d == ASSERT);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      low_seen_q <= 1'b0;
      ndm_q      <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      low_seen_q <= low_seen_d;
      ndm_q      <= ndm_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ndmreset_o = ndm_q;
  assign busy_o     = busy_q;
  assign timeout_o  = timeout_q;

`ifdef RST_REQ_CAUSE_EN
  logic [3:0] cause_q, cause_d;

  // New causes are OR-ed in after the clear so a same-cycle set wins.
  always_comb begin
    cause_d = cause_clr_i ? '0 : cause_q;
    cause_d = cause_d | {timeout_d, dbg_ndmreset_i, wdog_rst_req_i, sw_rst_req_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cause_q <= '0;
    end else begin
      cause_q <= cause_d;
    end
  end

  assign rst_cause_o = cause_q;
`else
  logic unused_cause_clr;
  assign unused_cause_clr = cause_clr_i;
  assign rst_cause_o      = '0;
`endif

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Directed bench for rst_req_ctrl with a 2-flop reset-manager model on ~ndmreset_o.
module tb_rst_req_ctrl;

`ifdef RST_REQ_CAUSE_EN
  localparam bit CauseEn = 1'b1;
`else
  localparam bit CauseEn = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       sw_rst_req_i, wdog_rst_req_i, dbg_ndmreset_i, sys_rst_ni_i, cause_clr_i;
  logic       ndmreset_o, busy_o, timeout_o;
  logic [3:0] rst_cause_o;

  logic       rm1, rm2;
  int         sys_mode;  // 0: reset-manager model, 1: tied high, 2: tied low

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  logic [127:0] ndm_v, busy_v, to_v;

  always #5 clk_i = ~clk_i;

  rst_req_ctrl #(.MinPulse(4), .TimeoutCycles(64)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sw_rst_req_i   (sw_rst_req_i),
    .wdog_rst_req_i (wdog_rst_req_i),
    .dbg_ndmreset_i (dbg_ndmreset_i),
    .sys_rst_ni_i   (sys_rst_ni_i),
    .cause_clr_i    (cause_clr_i),
    .ndmreset_o     (ndmreset_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o),
    .rst_cause_o    (rst_cause_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rm1 <= 1'b1;
      rm2 <= 1'b1;
    end else begin
      rm1 <= ~ndmreset_o;
      rm2 <= rm1;
    end
  end

  assign sys_rst_ni_i = (sys_mode == 1) ? 1'b1 : (sys_mode == 2) ? 1'b0 : rm2;

  function automatic logic [127:0] mask(input int a, input int b);
    logic [127:0] m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] ecause(input logic [3:0] v);
    return CauseEn ? v : 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_test();
    cyc_n  = 0;
    ndm_v  = '0;
    busy_v = '0;
    to_v   = '0;
  endtask

  // One clock cycle: drive inputs, sample outputs at the falling edge, advance past the rising edge.
  task automatic cyc(input logic sw, input logic wd, input logic dbg, input logic clr);
    sw_rst_req_i   = sw;
    wdog_rst_req_i = wd;
    dbg_ndmreset_i = dbg;
    cause_clr_i    = clr;
    @(negedge clk_i);
    if (cyc_n < 128) begin
      ndm_v[cyc_n]  = ndmreset_o;
      busy_v[cyc_n] = busy_o;
      to_v[cyc_n]   = timeout_o;
    end
    cyc_n++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_cause(input string tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk(tag, 128'(rst_cause_o), 128'(4'b0000));
  endtask

  initial begin
    rst_ni = 1'b0;
    sw_rst_req_i = 1'b0; wdog_rst_req_i = 1'b0; dbg_ndmreset_i = 1'b0; cause_clr_i = 1'b0;
    sys_mode = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ndm",   128'(ndmreset_o),  128'(1'b0));
    chk("rst_busy",  128'(busy_o),      128'(1'b0));
    chk("rst_to",    128'(timeout_o),   128'(1'b0));
    chk("rst_cause", 128'(rst_cause_o), 128'(4'b0000));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(2);

    // Software pulse: normal handshake
    start_test();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(11);
    chk("sw_ndm",   ndm_v,  mask(1, 4));
    chk("sw_busy",  busy_v, mask(1, 7));
    chk("sw_to",    to_v,   '0);
    chk("sw_cause", 128'(rst_cause_o), 128'(ecause(4'b0001)));
    clear_cause("clr1");

    // Debug level held 20 cycles
    start_test();
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("dbg_ndm",   ndm_v,  mask(1, 20));
    chk("dbg_busy",  busy_v, mask(1, 23));
    chk("dbg_to",    to_v,   '0);
    chk("dbg_cause", 128'(rst_cause_o), 128'(ecause(4'b0100)));
    clear_cause("clr2");

    // Reset manager never acknowledges: timeout in ASSERT
    sys_mode = 1;
    start_test();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(69);
    chk("ato_ndm",   ndm_v,  mask(1, 64));
    chk("ato_busy",  busy_v, mask(1, 64));
    chk("ato_to",    to_v,   mask(65, 65));
    chk("ato_cause", 128'(rst_cause_o), 128'(ecause(4'b1010)));
    sys_mode = 0;
    clear_cause("clr3");

    // System reset never returns: timeout in RELEASE
    sys_mode = 2;
    start_test();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(72);
    chk("rto_ndm",   ndm_v,  mask(1, 4));
    chk("rto_busy",  busy_v, mask(1, 68));
    chk("rto_to",    to_v,   mask(69, 69));
    chk("rto_cause", 128'(rst_cause_o), 128'(ecause(4'b1001)));
    sys_mode = 0;
    idle(3);
    clear_cause("clr4");

    // Simultaneous sw+wdog, then sw again mid-ASSERT
    start_test();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(11);
    chk("sim_ndm",   ndm_v,  mask(1, 4));
    chk("sim_busy",  busy_v, mask(1, 7));
    chk("sim_to",    to_v,   '0);
    chk("sim_cause", 128'(rst_cause_o), 128'(ecause(4'b0011)));

    // Clear and new cause in the same cycle: the new cause survives
    start_test();
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    idle(11);
    chk("clrset_ndm",   ndm_v, mask(1, 4));
    chk("clrset_cause", 128'(rst_cause_o), 128'(ecause(4'b0010)));

    // Power-on reset mid-ASSERT aborts the sequence
    start_test();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("abort_pre_ndm", 128'(ndmreset_o), 128'(1'b1));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("abort_ndm",   128'(ndmreset_o),  128'(1'b0));
    chk("abort_busy",  128'(busy_o),      128'(1'b0));
    chk("abort_to",    128'(timeout_o),   128'(1'b0));
    chk("abort_cause", 128'(rst_cause_o), 128'(4'b0000));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    start_test();
    idle(10);
    chk("post_ndm",  ndm_v,  '0);
    chk("post_busy", busy_v, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
